// File: rtl/line_window_ctrl_pkg.sv
// Shared definitions for the line window controller: FSM encoding, default
// geometry, operator height limits and error flag bit positions.
package line_window_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_LINE  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DEF_ADDR_WIDTH = 11;
  localparam int OP_HEIGHT_MIN  = 3;
  localparam int OP_HEIGHT_MAX  = 7;
  localparam int LINE_COUNT_W   = 12;

  localparam int ERR_OVF = 0;
  localparam int ERR_LEN = 1;

endpackage

// File: rtl/line_window_ctrl_en_delay_line.sv
// Parameterised-depth shift register used to align write strobes, operator
// enables and window flags with the line buffer read latency.
module en_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DEPTH-1];

endmodule

// File: rtl/line_window_ctrl.sv
// Frame/line sequencer for a line-buffered 2-D operator: generates line buffer
// addresses and strobes, counts lines, tracks line width and flags errors.
module line_window_ctrl
  import line_window_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int OPERATOR_HEIGHT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Vsync,
  input  logic                    DataEn,
  output logic [ADDR_WIDTH-1:0]   addra,
  output logic [ADDR_WIDTH-1:0]   addrb,
  output logic                    web,
  output logic                    OperatorDataEn,
  output logic                    WindowValid,
  output logic [LINE_COUNT_W-1:0] LineCount,
  output logic [ADDR_WIDTH:0]     LineWidth,
  output logic                    FrameDone,
  output logic [1:0]              ErrFlags
);

  generate
    if (DATA_WIDTH < 1 || ADDR_WIDTH < 1 ||
        OPERATOR_HEIGHT < OP_HEIGHT_MIN || OPERATOR_HEIGHT > OP_HEIGHT_MAX ||
        (OPERATOR_HEIGHT % 2) == 0) begin : g_bad_param
      $error("line_window_ctrl: illegal parameter combination");
    end
  endgenerate

  localparam logic [ADDR_WIDTH:0]     MAX_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0]   MAX_COL = '1;
  localparam logic [LINE_COUNT_W-1:0] LC_MAX  = '1;
  localparam logic [LINE_COUNT_W-1:0] LC_GATE = LINE_COUNT_W'(OPERATOR_HEIGHT - 1);
  localparam logic [ADDR_WIDTH+1:0]   HALF_X  = (ADDR_WIDTH+2)'((OPERATOR_HEIGHT - 1) / 2);
  localparam int                      S1_W    = ADDR_WIDTH + 3;

  state_e                  state_q, state_d;
  logic                    vlow_q;
  logic [ADDR_WIDTH:0]     pix_cnt_q, pix_cnt_d;
  logic [LINE_COUNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [ADDR_WIDTH:0]     line_width_q, line_width_d;
  logic [1:0]              err_q, err_d;

  logic                    vs_rise, in_frame, pix, line_end, col_sat;
  logic [ADDR_WIDTH-1:0]   col;
  logic [ADDR_WIDTH+1:0]   col_x;
  logic                    web_in, ode_in, win_in, win_d1;
  logic [S1_W-1:0]         s1_in, s1_out;

  // vlow_q starts at 0, so a Vsync already high when reset releases is never
  // mistaken for a rising edge; a frame must begin from a seen-low Vsync.
  assign vs_rise  = Vsync & vlow_q;
  assign in_frame = (state_q == ST_FRAME) || (state_q == ST_LINE);
  assign pix      = in_frame & Vsync & DataEn;
  assign line_end = (state_q == ST_LINE) & (~DataEn | ~Vsync);
  assign col_sat  = (pix_cnt_q == MAX_CNT);
  assign col      = col_sat ? MAX_COL : pix_cnt_q[ADDR_WIDTH-1:0];
  assign col_x    = {2'b00, col};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      vlow_q       <= 1'b0;
      pix_cnt_q    <= '0;
      line_cnt_q   <= '0;
      line_width_q <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      vlow_q       <= ~Vsync;
      pix_cnt_q    <= pix_cnt_d;
      line_cnt_q   <= line_cnt_d;
      line_width_q <= line_width_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (vs_rise) state_d = ST_FRAME;
      ST_FRAME: begin
        if (!Vsync)      state_d = ST_DONE;
        else if (DataEn) state_d = ST_LINE;
      end
      ST_LINE: begin
        if (!Vsync)       state_d = ST_DONE;
        else if (!DataEn) state_d = ST_FRAME;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pix_cnt_d    = pix_cnt_q;
    line_cnt_d   = line_cnt_q;
    line_width_d = line_width_q;
    err_d        = err_q;
    if (state_q == ST_IDLE && vs_rise) begin
      pix_cnt_d    = '0;
      line_cnt_d   = '0;
      line_width_d = '0;
      err_d        = '0;
    end else begin
      // Pixels past the last address keep reading the final column, never write.
      if (pix && !col_sat) pix_cnt_d = pix_cnt_q + 1'b1;
      if (pix && col_sat)  err_d[ERR_OVF] = 1'b1;
      if (line_end) begin
        pix_cnt_d = '0;
        if (line_cnt_q != LC_MAX) line_cnt_d = line_cnt_q + 1'b1;
        if (line_cnt_q == '0)                 line_width_d = pix_cnt_q;
        else if (pix_cnt_q != line_width_q)   err_d[ERR_LEN] = 1'b1;
      end
    end
  end

  // Window flag carries the centre-column range test alongside the enable.
  assign web_in = pix & ~col_sat;
  assign ode_in = pix & (line_cnt_q >= LC_GATE);
  assign win_in = ode_in & (col_x >= HALF_X) & ((col_x + HALF_X) < {1'b0, line_width_q});
  assign s1_in  = {col, web_in, ode_in, win_in};

  en_delay_line #(
    .WIDTH (S1_W),
    .DEPTH (1)
  ) u_stage1 (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (s1_in),
    .dout  (s1_out)
  );

  assign addrb          = s1_out[S1_W-1:3];
  assign web            = s1_out[2];
  assign OperatorDataEn = s1_out[1];
  assign win_d1         = s1_out[0];

  en_delay_line #(
    .WIDTH (1),
    .DEPTH (OPERATOR_HEIGHT - 1)
  ) u_win (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (win_d1),
    .dout  (WindowValid)
  );

  assign addra     = col;
  assign LineCount = line_cnt_q;
  assign LineWidth = line_width_q;
  assign ErrFlags  = err_q;
  assign FrameDone = (state_q == ST_DONE);

endmodule

// File: tb/tb_line_window_ctrl.sv
// Directed bench for line_window_ctrl with hand-computed expectations.
module tb_line_window_ctrl;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst_n, Vsync, DataEn;
  logic [AW-1:0] addra, addrb;
  logic          web, OperatorDataEn, WindowValid, FrameDone;
  logic [11:0]   LineCount;
  logic [AW:0]   LineWidth;
  logic [1:0]    ErrFlags;

  int n_checks = 0;
  int n_fail   = 0;
  int ode_cnt  = 0;
  int wv_cnt   = 0;
  int fd_cnt   = 0;
  int web_cnt  = 0;

  always #5 clk = ~clk;

  line_window_ctrl #(
    .DATA_WIDTH      (8),
    .ADDR_WIDTH      (AW),
    .OPERATOR_HEIGHT (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .Vsync          (Vsync),
    .DataEn         (DataEn),
    .addra          (addra),
    .addrb          (addrb),
    .web            (web),
    .OperatorDataEn (OperatorDataEn),
    .WindowValid    (WindowValid),
    .LineCount      (LineCount),
    .LineWidth      (LineWidth),
    .FrameDone      (FrameDone),
    .ErrFlags       (ErrFlags)
  );

  always @(negedge clk) begin
    if (OperatorDataEn === 1'b1) ode_cnt++;
    if (WindowValid === 1'b1)    wv_cnt++;
    if (FrameDone === 1'b1)      fd_cnt++;
    if (web === 1'b1)            web_cnt++;
  end

  task automatic step(input logic v, input logic d);
    Vsync  = v;
    DataEn = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic do_line(input int n);
    repeat (n) step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
  endtask

  task automatic clr_cnt();
    ode_cnt = 0;
    wv_cnt  = 0;
    fd_cnt  = 0;
    web_cnt = 0;
  endtask

  initial begin
    rst_n  = 1'b0;
    Vsync  = 1'b0;
    DataEn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_addra", addra, 0);
    check("rst_addrb", addrb, 0);
    check("rst_web", web, 0);
    check("rst_ode", OperatorDataEn, 0);
    check("rst_wv", WindowValid, 0);
    check("rst_linecount", LineCount, 0);
    check("rst_linewidth", LineWidth, 0);
    check("rst_framedone", FrameDone, 0);
    check("rst_errflags", ErrFlags, 0);
    rst_n = 1'b1;
    repeat (2) step(1'b0, 1'b0);

    // Frame 1: 5 lines of 8 pixels
    clr_cnt();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("first_web", web, 1);
    check("first_addrb", addrb, 0);
    check("second_addra", addra, 1);
    repeat (7) step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    check("lw_after_line0", LineWidth, 8);
    check("lc_after_line0", LineCount, 1);
    repeat (4) do_line(8);
    step(1'b0, 1'b0);
    check("framedone_pulse", FrameDone, 1);
    step(1'b0, 1'b0);
    check("framedone_drop", FrameDone, 0);
    repeat (4) step(1'b0, 1'b0);
    check("f1_linecount", LineCount, 5);
    check("f1_linewidth", LineWidth, 8);
    check("f1_errflags", ErrFlags, 0);
    check("f1_ode_cycles", ode_cnt, 24);
    check("f1_wv_cycles", wv_cnt, 18);
    check("f1_framedone_count", fd_cnt, 1);
    check("f1_web_cycles", web_cnt, 40);

    // Frame 2: line length mismatch
    step(1'b1, 1'b0);
    check("f2_lc_cleared", LineCount, 0);
    do_line(8);
    do_line(6);
    check("f2_errflags", ErrFlags, 2);
    check("f2_linecount", LineCount, 2);
    repeat (3) step(1'b0, 1'b0);
    check("f2_err_hold_idle", ErrFlags, 2);
    check("f2_lc_hold_idle", LineCount, 2);

    // Frame 3: overflow on a 2050-pixel line
    step(1'b1, 1'b0);
    check("f3_err_cleared", ErrFlags, 0);
    for (int k = 0; k < 2050; k++) begin
      step(1'b1, 1'b1);
      if (k == 2047) begin
        check("ovf_last_web", web, 1);
        check("ovf_last_addrb", addrb, 2047);
        check("ovf_last_addra", addra, 2047);
        check("ovf_last_err", ErrFlags, 0);
      end
      if (k == 2048) begin
        check("ovf_web_off", web, 0);
        check("ovf_addra_hold", addra, 2047);
        check("ovf_err_set", ErrFlags, 1);
      end
      if (k == 2049) begin
        check("ovf_web_off2", web, 0);
        check("ovf_addra_hold2", addra, 2047);
      end
    end
    repeat (4) step(1'b1, 1'b0);
    check("f3_linewidth", LineWidth, 2048);
    check("f3_linecount", LineCount, 1);
    check("f3_errflags", ErrFlags, 1);
    repeat (3) step(1'b0, 1'b0);

    // Frame 4: reset pulse during line 2
    step(1'b1, 1'b0);
    do_line(8);
    do_line(8);
    repeat (3) step(1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_linecount", LineCount, 0);
    check("mid_rst_linewidth", LineWidth, 0);
    check("mid_rst_addra", addra, 0);
    check("mid_rst_addrb", addrb, 0);
    check("mid_rst_web", web, 0);
    check("mid_rst_ode", OperatorDataEn, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clr_cnt();
    repeat (3) step(1'b1, 1'b1);
    repeat (2) step(1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1);
    check("post_rst_linecount", LineCount, 0);
    check("post_rst_addra", addra, 0);
    check("post_rst_web_cycles", web_cnt, 0);
    repeat (2) step(1'b0, 1'b0);
    check("post_rst_no_framedone", fd_cnt, 0);
    step(1'b1, 1'b0);
    do_line(8);
    check("rejoin_linecount", LineCount, 1);
    repeat (3) step(1'b0, 1'b0);

    // Frame 5: Vsync falls while DataEn is high
    step(1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    check("vfall_linecount", LineCount, 1);
    check("vfall_framedone", FrameDone, 1);
    check("vfall_linewidth", LineWidth, 8);
    step(1'b0, 1'b0);
    check("vfall_framedone_drop", FrameDone, 0);

    // DataEn toggling outside a frame
    clr_cnt();
    for (int i = 0; i < 10; i++) step(1'b0, logic'(i % 2));
    check("idle_web_cycles", web_cnt, 0);
    check("idle_ode_cycles", ode_cnt, 0);
    check("idle_wv_cycles", wv_cnt, 0);
    check("idle_linecount", LineCount, 1);
    step(1'b0, 1'b0);

    // Vsync rise together with DataEn: that pixel is dropped
    step(1'b1, 1'b1);
    check("rise_pix_addra", addra, 0);
    check("rise_pix_web", web, 0);
    repeat (7) step(1'b1, 1'b1);
    repeat (4) step(1'b1, 1'b0);
    check("rise_pix_linewidth", LineWidth, 7);
    repeat (3) step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_window_ctrl.md
LINE_WINDOW_CTRL -- requirements
Module: line_window_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8, sets the pixel bit width; this block uses it only for documentation and width checks.
REQ-002 Parameter ADDR_WIDTH, default 11, sets the line buffer address width; maximum line length is 2^ADDR_WIDTH pixels.
REQ-003 Parameter OPERATOR_HEIGHT, default 3, is the operator window height; legal range is 3 to 7, odd only.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 Vsync  in  1  frame enable; high for the whole frame.
REQ-008 DataEn  in  1  pixel valid; each high run is one line.
REQ-009 addra  out  ADDR_WIDTH  line buffer read address.
REQ-010 addrb  out  ADDR_WIDTH  line buffer write address.
REQ-011 web  out  1  line buffer write enable.
REQ-012 OperatorDataEn  out  1  operator column data valid.
REQ-013 WindowValid  out  1  full window present around the centre pixel; aligned with the operator result (DataOutEn).
REQ-014 LineCount  out  12  number of lines completed in the current frame.
REQ-015 LineWidth  out  ADDR_WIDTH+1  pixel count of the first line of the frame.
REQ-016 FrameDone  out  1  one-cycle pulse at the end of a frame.
REQ-017 ErrFlags  out  2  sticky per frame: bit0 overflow, bit1 line-length mismatch.

Function
REQ-018 FSM states: IDLE, FRAME, LINE, DONE.
REQ-019 IDLE -> FRAME on the Vsync rising edge; FRAME -> LINE when DataEn=1; LINE -> FRAME when DataEn falls; FRAME or LINE -> DONE when Vsync falls; DONE -> IDLE after one cycle.
REQ-020 DataEn is ignored outside FRAME and LINE: addresses hold, web=0, and no output pulses are produced.
REQ-021 Column counter col is 0 on the first DataEn=1 cycle of a line and increments on each following DataEn=1 cycle.
REQ-022 addra equals col in the same cycle as DataEn; douta is valid one cycle later.
REQ-023 addrb and web are addra and DataEn delayed by 1 cycle (read-before-write at the same address).
REQ-024 Each DataEn falling edge (1->0), or a Vsync fall while in LINE, ends the line: col clears and LineCount increments, saturating at 4095.
REQ-025 OperatorDataEn is DataEn delayed 1 cycle, gated by LineCount >= OPERATOR_HEIGHT-1 at the time the pixel was sampled.
REQ-026 WindowValid is OperatorDataEn delayed OPERATOR_HEIGHT-1 cycles, and is high only while the centre column lies in [(H-1)/2, LineWidth-1-(H-1)/2], where H = OPERATOR_HEIGHT.
REQ-027 LineWidth captures the final col+1 at the end of line 0; it is 0 until then.
REQ-028 A later line whose length differs from LineWidth sets ErrFlags[1]; that line is still processed.
REQ-029 When col reaches 2^ADDR_WIDTH-1, col saturates, ErrFlags[0] sets, and web is forced to 0 for the remainder of that line.
REQ-030 FrameDone pulses in the DONE state; LineCount, LineWidth and ErrFlags hold until the next Vsync rising edge, then clear.
REQ-031 If the Vsync rise and DataEn=1 occur in the same cycle, the FSM enters FRAME and that pixel is not counted.

Reset
REQ-032 While rst_n=0: FSM=IDLE and every output and internal counter is 0.
REQ-033 After a mid-frame reset, the block waits for the next Vsync rising edge; it never joins a frame that is already in progress.

Structure
REQ-034 Shared package holds: the FSM state encoding, default ADDR_WIDTH, OPERATOR_HEIGHT limits, and the ErrFlags bit indices.
REQ-035 Sub-module en_delay_line (parameterised-depth shift register) implements the REQ-023, REQ-025 and REQ-026 delays; everything else is flat.

Verification
REQ-036 Frame of 5 lines x 8 px, 4 idle cycles between lines -> LineWidth=8, LineCount=5, FrameDone=1 once, OperatorDataEn high for 24 cycles, WindowValid high for 18 cycles.
REQ-037 Line 0 of 8 px, line 1 of 6 px -> ErrFlags=2'b10; LineCount still increments.
REQ-038 Line of 2050 px with ADDR_WIDTH=11 -> ErrFlags[0]=1, web=0 after col=2047, addra holds at 2047.
REQ-039 rst_n pulsed low during line 2, Vsync still high -> all outputs 0; DataEn ignored until Vsync falls and rises again.
REQ-040 DataEn high in the cycle Vsync falls -> line counted, LineCount increments, FrameDone pulses the next cycle.
REQ-041 DataEn toggling while Vsync=0 -> web, OperatorDataEn and WindowValid stay 0, and LineCount is unchanged.
